// File: rtl/ifu_imem_resp_if.sv
// rtl/ifu_imem_resp_if.sv - fetch request/response handshake bundle between fetch unit and imem responder
interface ifu_imem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic [31:0] rsp_addr;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_err
  );
endinterface

// File: rtl/ifu_imem_resp.sv
// rtl/ifu_imem_resp.sv - fixed-latency instruction-memory responder with flush and load port
// Defining IFU_IMEM_STAT_EN adds stat_fetch/stat_err delivered-response counters.
module ifu_imem_resp #(
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  ifu_imem_resp_if.slave        bus,
  input  logic                  flush,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_idx,
  input  logic [31:0]           ld_data
`ifdef IFU_IMEM_STAT_EN
  ,
  output logic [31:0]           stat_fetch,
  output logic [31:0]           stat_err
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0]  CNT_INIT  = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [32:0] MEM_BYTES = 33'd4 << DEPTH_LOG2;

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_inst_q, rsp_inst_d;
  logic [31:0] rsp_addr_q, rsp_addr_d;
  logic        rsp_err_q, rsp_err_d;

  logic                  req_ready;
  logic                  accept;
  logic                  enter_resp;
  logic [31:0]           fetch_addr;
  logic [31:0]           offset;
  logic                  fetch_err;
  logic [DEPTH_LOG2-1:0] fetch_idx;

  // A one-cycle latency fetch enters RESP straight from the request, so look at req_addr then.
  always_comb begin
    req_ready  = !flush && (state_q == IDLE || (state_q == RESP && bus.rsp_ready));
    accept     = bus.req_valid && req_ready;
    fetch_addr = accept ? bus.req_addr : addr_q;
    offset     = fetch_addr - BASE;
    fetch_err  = (fetch_addr[1:0] != 2'b00) || (fetch_addr < BASE) || ({1'b0, offset} >= MEM_BYTES);
    fetch_idx  = offset[DEPTH_LOG2+1:2];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_inst_d  = rsp_inst_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_err_d   = rsp_err_q;
    enter_resp  = 1'b0;
    if (flush && state_q != IDLE) begin
      state_d     = IDLE;
      rsp_valid_d = 1'b0;
      cnt_d       = 4'd0;
    end else if (state_q == WAIT) begin
      if (cnt_q == 4'd0) enter_resp = 1'b1;
      else               cnt_d      = cnt_q - 4'd1;
    end else begin
      if (state_q == RESP && bus.rsp_ready) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
      if (accept) begin
        addr_d = bus.req_addr;
        if (LATENCY == 1) begin
          enter_resp = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
    end
    if (enter_resp) begin
      state_d     = RESP;
      rsp_valid_d = 1'b1;
      rsp_addr_d  = fetch_addr;
      rsp_err_d   = fetch_err;
      rsp_inst_d  = fetch_err ? 32'd0 : mem[fetch_idx];
    end
  end

`ifdef IFU_IMEM_STAT_EN
  logic [31:0] stat_fetch_q, stat_fetch_d;
  logic [31:0] stat_err_q, stat_err_d;
  logic        delivered;

  // A handshake in a flush cycle still counts: flush only cancels what has not been taken.
  always_comb begin
    delivered    = rsp_valid_q && bus.rsp_ready;
    stat_fetch_d = stat_fetch_q + {31'd0, delivered};
    stat_err_d   = stat_err_q + {31'd0, delivered && rsp_err_q};
  end

  assign stat_fetch = stat_fetch_q;
  assign stat_err   = stat_err_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= BASE;
      rsp_valid_q  <= 1'b0;
      rsp_inst_q   <= 32'd0;
      rsp_addr_q   <= BASE;
      rsp_err_q    <= 1'b0;
`ifdef IFU_IMEM_STAT_EN
      stat_fetch_q <= 32'd0;
      stat_err_q   <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_inst_q   <= rsp_inst_d;
      rsp_addr_q   <= rsp_addr_d;
      rsp_err_q    <= rsp_err_d;
`ifdef IFU_IMEM_STAT_EN
      stat_fetch_q <= stat_fetch_d;
      stat_err_q   <= stat_err_d;
`endif
    end
  end

  // Memory is not reset; a same-edge load and RESP-entry read yields the old word.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_data;
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_inst  = rsp_inst_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ifu_imem_resp.sv
// tb/tb_ifu_imem_resp.sv - self-checking bench for ifu_imem_resp with a timeline-based reference model
module tb_ifu_imem_resp;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int DL  = 12;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic ld_en = 1'b0;
  logic [DL-1:0] ld_idx = '0;
  logic [31:0] ld_data = '0;
  int total = 0;
  int bad = 0;

  ifu_imem_resp_if bus ();

`ifdef IFU_IMEM_STAT_EN
  logic [31:0] stat_fetch, stat_err;
`endif

  ifu_imem_resp #(.BASE(BASE), .DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .flush(flush),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
`ifdef IFU_IMEM_STAT_EN
    , .stat_fetch(stat_fetch), .stat_err(stat_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a request accepted at edge k surfaces at edge k+LAT-1.
  logic [31:0] mmem [0:(1<<DL)-1];
  bit          m_busy = 0;
  bit          m_valid = 0;
  logic [31:0] m_addr = '0, m_inst = '0, m_raddr = '0;
  bit          m_err = 0;
  longint      ecnt = 0, m_due = 0;
  logic [31:0] m_fetch = '0, m_nerr = '0;

  function automatic bit addr_bad(input logic [31:0] a);
    longint la = longint'(a);
    return (a % 4 != 0) || (la < longint'(BASE)) || (la >= longint'(BASE) + (longint'(4) << DL));
  endfunction

  initial forever begin
    bit hs, acc;
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_busy = 0; m_valid = 0; m_fetch = '0; m_nerr = '0; m_raddr = BASE;
    end else begin
      ecnt++;
      hs  = m_valid && bus.rsp_ready;
      acc = bus.req_valid && !flush && (!m_busy || hs);
      if (hs) begin
        m_fetch++;
        if (m_err) m_nerr++;
      end
      if (flush && m_busy) begin
        m_busy = 0; m_valid = 0;
      end else begin
        if (hs) begin m_valid = 0; m_busy = 0; end
        if (acc) begin m_busy = 1; m_addr = bus.req_addr; m_due = ecnt + LAT - 1; end
        if (m_busy && !m_valid && ecnt == m_due) begin
          m_valid = 1;
          m_raddr = m_addr;
          m_err   = addr_bad(m_addr);
          m_inst  = m_err ? 32'd0 : mmem[(m_addr - BASE) / 4];
        end
      end
      if (ld_en) mmem[ld_idx] = ld_data;
    end
  end

  initial forever begin
    @(negedge clk);
    chkb("cmp_rsp_valid", bus.rsp_valid, m_valid);
    chkb("cmp_req_ready", bus.req_ready, !flush && (!m_busy || (m_valid && bus.rsp_ready)));
    if (m_valid) begin
      chk("cmp_rsp_inst", bus.rsp_inst, m_inst);
      chk("cmp_rsp_addr", bus.rsp_addr, m_raddr);
      chkb("cmp_rsp_err", bus.rsp_err, m_err);
    end
`ifdef IFU_IMEM_STAT_EN
    chk("cmp_stat_fetch", stat_fetch, m_fetch);
    chk("cmp_stat_err", stat_err, m_nerr);
`endif
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    ld_en = 1'b1; ld_idx = DL'(idx); ld_data = d;
    tick;
    ld_en = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a);
    int n = 0;
    bus.req_valid = 1'b1; bus.req_addr = a;
    while (!bus.req_ready && n < 20) begin tick; n++; end
    if (n >= 20) chkb("req_ready_timeout", bus.req_ready, 1'b1);
    tick;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin tick; n++; end
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic ee);
    int n;
    bus.rsp_ready = 1'b1;
    issue(a);
    wait_rsp(n);
    chk("fetch_latency", n, LAT - 1);
    chk("fetch_inst", bus.rsp_inst, ei);
    chkb("fetch_err", bus.rsp_err, ee);
    chk("fetch_addr", bus.rsp_addr, a);
    tick;
  endtask

  task automatic async_reset;
    #2 rst = 1'b0;
    #1;
    chkb("areset_rsp_valid", bus.rsp_valid, 1'b0);
    chk("areset_rsp_addr", bus.rsp_addr, BASE);
    chk("areset_rsp_inst", bus.rsp_inst, 32'd0);
    tick;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [31:0] h_inst, h_addr;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.rsp_ready = 1'b0;
    repeat (3) tick;
    chkb("reset_rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset_rsp_addr", bus.rsp_addr, 32'h8000_0000);
    chk("reset_rsp_inst", bus.rsp_inst, 32'd0);
    chkb("reset_rsp_err", bus.rsp_err, 1'b0);
    rst = 1'b1;
    tick;

    load(0, 32'h0000_0297);
    load(1, 32'h0002_8823);
    load(2, 32'hDEAD_BEEF);
    load(3, 32'h0000_0013);
    load(4095, 32'hCAFE_F00D);

    fetch(32'h8000_0000, 32'h0000_0297, 1'b0);
    fetch(32'h8000_0004, 32'h0002_8823, 1'b0);
    fetch(32'h8000_0002, 32'h0000_0000, 1'b1);
    fetch(32'h7FFF_FFFC, 32'h0000_0000, 1'b1);
    fetch(32'h8000_4000, 32'h0000_0000, 1'b1);
    fetch(32'h8000_3FFC, 32'hCAFE_F00D, 1'b0);

    // Held response, then release with a same-cycle accept.
    bus.rsp_ready = 1'b0;
    issue(32'h8000_0004);
    wait_rsp(n);
    h_inst = bus.rsp_inst; h_addr = bus.rsp_addr;
    chk("hold_first_inst", h_inst, 32'h0002_8823);
    for (int i = 0; i < 5; i++) begin
      tick;
      chkb("hold_valid", bus.rsp_valid, 1'b1);
      chk("hold_inst", bus.rsp_inst, h_inst);
      chk("hold_addr", bus.rsp_addr, h_addr);
      chkb("hold_req_ready", bus.req_ready, 1'b0);
    end
    bus.req_valid = 1'b1; bus.req_addr = 32'h8000_0008; bus.rsp_ready = 1'b1;
    #1;
    chkb("release_req_ready", bus.req_ready, 1'b1);
    tick;
    bus.req_valid = 1'b0;
    wait_rsp(n);
    chk("b2b_latency", n, LAT - 1);
    chk("b2b_inst", bus.rsp_inst, 32'hDEAD_BEEF);
    tick;

    // Load to the word being read on the RESP-entry edge returns the old word.
    issue(32'h8000_000C);
    load(3, 32'h0000_0077);
    wait_rsp(n);
    chk("collide_inst", bus.rsp_inst, 32'h0000_0013);
    tick;
    fetch(32'h8000_000C, 32'h0000_0077, 1'b0);

    // Flush while waiting, then flush against a new request in IDLE.
    issue(32'h8000_0000);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    repeat (4) tick;
    chkb("flush_wait_no_rsp", bus.rsp_valid, 1'b0);
    bus.req_valid = 1'b1; bus.req_addr = 32'h8000_0004; flush = 1'b1;
    #1;
    chkb("flush_req_ready", bus.req_ready, 1'b0);
    tick;
    bus.req_valid = 1'b0; flush = 1'b0;
    repeat (4) tick;
    chkb("flush_req_not_taken", bus.rsp_valid, 1'b0);

    // Async reset mid-WAIT and mid-RESP.
    issue(32'h8000_0000);
    async_reset;
    repeat (3) tick;
    chkb("reset_wait_dropped", bus.rsp_valid, 1'b0);
    bus.rsp_ready = 1'b0;
    issue(32'h8000_0000);
    wait_rsp(n);
    chkb("pre_reset_resp_valid", bus.rsp_valid, 1'b1);
    async_reset;
    fetch(32'h8000_0004, 32'h0002_8823, 1'b0);

    // Delivered-response counting after a fresh reset.
    async_reset;
    fetch(32'h8000_0000, 32'h0000_0297, 1'b0);
    fetch(32'h8000_0004, 32'h0002_8823, 1'b0);
    fetch(32'h8000_0008, 32'hDEAD_BEEF, 1'b0);
    fetch(32'h8000_0001, 32'h0000_0000, 1'b1);
    issue(32'h8000_000C);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    repeat (3) tick;
`ifdef IFU_IMEM_STAT_EN
    chk("stat_fetch_total", stat_fetch, 32'd4);
    chk("stat_err_total", stat_err, 32'd1);
`endif
    chkb("final_idle", bus.rsp_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ifu_imem_resp.md
Name: ifu_imem_resp

Overview:
- Instruction-memory responder on the fetch interface; the target end of the PC generator's fetch-address stream.
- Accepts one fetch request at a time via valid/ready, with a fixed LATENCY.
- Returns instruction word, echoed address and error flag via valid/ready.
- Supports flush on jump/branch redirect. Memory is an internal word array, preloaded through a load port.

Parameters:
- BASE, 32'h80000000, byte address of word 0
- DEPTH_LOG2, 12, log2 of memory depth in 32-bit words
- LATENCY, 2, cycles from request accept to rsp_valid; legal range 1..15

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  fetch request valid
- req_ready  out  1  responder can accept request
- req_addr  in  32  fetch byte address
- flush  in  1  redirect; cancels in-flight/held response
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_inst  out  32  instruction word
- rsp_addr  out  32  address of returned instruction
- rsp_err  out  1  misaligned or out-of-range fetch
- ld_en  in  1  memory load strobe
- ld_idx  in  DEPTH_LOG2  word index to load
- ld_data  in  32  word to load

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; rsp_valid=0, rsp_inst=0, rsp_addr=BASE, rsp_err=0, internal counter=0.
  - Memory contents not reset.
- States:
  - IDLE: no request outstanding.
  - WAIT: counting latency.
  - RESP: response held.
- req_ready = !flush && (state==IDLE || (state==RESP && rsp_ready)).
- Accept = req_valid && req_ready:
  - Latch req_addr.
  - If LATENCY==1, go directly to RESP next cycle; else load counter with LATENCY-2 and go to WAIT.
- WAIT: decrement counter each cycle; when counter==0, go to RESP next cycle.
- Entry into RESP: drive rsp_valid=1, rsp_addr=latched addr.
  - rsp_inst = mem[(addr-BASE)>>2] sampled at that edge.
  - rsp_err = (addr[1:0]!=0) || addr<BASE || addr>=BASE+(4<<DEPTH_LOG2).
  - On error, rsp_inst=0.
- RESP:
  - Outputs stable while rsp_valid && !rsp_ready.
  - On rsp_ready with no accept, go to IDLE and clear rsp_valid.
  - On rsp_ready with a same-cycle accept, go back-to-back to WAIT/RESP as per the accept rule. Throughput is one fetch per LATENCY cycles.
- Flush (highest priority, not in IDLE):
  - Next state IDLE, rsp_valid=0, counter=0.
  - Same-cycle request is not accepted (req_ready=0).
  - A response handshaking in the flush cycle counts as delivered.
- Flush in IDLE: no effect beyond forcing req_ready=0.
- Load port:
  - Writes mem[ld_idx] on posedge when ld_en, in any state.
  - Collision with the RESP-entry read of the same index returns the old word (read-before-write).
- Address arithmetic is 32-bit unsigned.
- Upper-bound compare must not overflow for any DEPTH_LOG2 ≤ 20.

Optional Feature:
- Macro IFU_IMEM_STAT_EN.
- Defined: adds outputs stat_fetch [31:0] and stat_err [31:0].
  - stat_fetch increments on every rsp_valid && rsp_ready; stat_err increments on the same event when rsp_err=1.
  - Both wrap at 2^32, clear on reset, and are unaffected by flush.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Preload mem[0]=32'h00000297, mem[1]=32'h00028823; LATENCY=2; req 32'h80000000 then 32'h80000004, rsp_ready=1 -> rsp_valid 2 cycles after each accept, rsp_inst 32'h00000297 then 32'h00028823, rsp_err=0.
- Req 32'h80000002 -> rsp_err=1, rsp_inst=0, rsp_addr=32'h80000002; req 32'h7FFFFFFC and 32'h80004000 (DEPTH_LOG2=12) -> rsp_err=1.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_inst/rsp_addr constant, req_ready=0; release with req_valid=1 -> same-cycle accept, next response LATENCY cycles later.
- Flush one cycle after accept (WAIT) -> no rsp_valid for that request, state IDLE; flush with req_valid=1 -> req_ready=0, request not taken.
- Assert rst=0 asynchronously mid-WAIT and mid-RESP -> rsp_valid drops without a clock edge, rsp_addr=32'h80000000, preloaded memory still returns correct data after release.
- IFU_IMEM_STAT_EN defined: 3 good and 1 misaligned handshake, 1 flushed request -> stat_fetch=4, stat_err=1.
